// File: rtl/crypto_block.sv
// Two-byte toy AES core: one-hot FSM steps SubBytes/ShiftRows/MixCol/AddKey over 4 rounds.
// Encrypt result lands 32 edges after bgn is sampled (decrypt 31); bgn is ignored while busy.
module crypto_block (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_inbus,
  input  logic [15:0] data_inbus,
  input  logic [1:0]  cript_or_decript_signal,
  input  logic        bgn,
  output logic        c00, c01, c02, c03, c04, c05, c06, c07, c08, c09, c010,
  output logic        c011, c012, c013, c014, c015, c016, c017, c018, c019, c020, c021,
  output logic [2:0]  counter,
  output logic [15:0] key_outbus,
  output logic [15:0] data_outbus
);
  localparam logic [1:0] ENC = 2'b01;
  localparam logic [1:0] DEC = 2'b10;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [22:0] {
    S0   = 23'h000001, S1  = 23'h000002, S2  = 23'h000004, S3  = 23'h000008,
    S4   = 23'h000010, S5  = 23'h000020, S6  = 23'h000040, S7  = 23'h000080,
    S8   = 23'h000100, S9  = 23'h000200, S10 = 23'h000400, S11 = 23'h000800,
    S12  = 23'h001000, S14 = 23'h004000, S15 = 23'h008000, S16 = 23'h010000,
    S17  = 23'h020000, S18 = 23'h040000, S19 = 23'h080000, S20 = 23'h100000,
    S21  = 23'h200000, IDLE = 23'h400000
  } state_t;

  // Table entry x sits at bits {~x,3'b111} -: 8 because entry 0 is the MSB byte.
  function automatic logic [15:0] sub(input logic [15:0] s);
    return {SBOX[{~s[15:8], 3'b111} -: 8], SBOX[{~s[7:0], 3'b111} -: 8]};
  endfunction

  function automatic logic [15:0] isub(input logic [15:0] s);
    return {ISBOX[{~s[15:8], 3'b111} -: 8], ISBOX[{~s[7:0], 3'b111} -: 8]};
  endfunction

  function automatic logic [15:0] shift(input logic [15:0] s);
    return {s[15:8], s[3:0], s[7:4]};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // [[2,3],[3,2]] squares to identity in GF(2^8), so this also serves as InvMixCol.
  function automatic logic [15:0] mix(input logic [15:0] s);
    logic [7:0] b0, b1;
    b0 = s[15:8];
    b1 = s[7:0];
    return {xt(b0) ^ xt(b1) ^ b1, xt(b0) ^ b0 ^ xt(b1)};
  endfunction

  state_t      state;
  logic [22:0] sbits;
  logic [21:0] c_q;
  logic [2:0]  cnt;
  logic [1:0]  mode;
  logic [15:0] st, ky;

  assign sbits = state;
  assign {c021, c020, c019, c018, c017, c016, c015, c014, c013, c012, c011,
          c010, c09, c08, c07, c06, c05, c04, c03, c02, c01, c00} = c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      c_q         <= '0;
      cnt         <= '0;
      counter     <= '0;
      mode        <= '0;
      st          <= '0;
      ky          <= '0;
      data_outbus <= '0;
      key_outbus  <= '0;
    end else begin
      c_q     <= sbits[21:0] & ~22'h002000;
      counter <= cnt;
      case (state)
        IDLE: if (bgn && (cript_or_decript_signal == ENC || cript_or_decript_signal == DEC)) state <= S0;
        S0: begin
          mode  <= cript_or_decript_signal;
          st    <= data_inbus;
          ky    <= key_inbus;
          cnt   <= 3'd0;
          state <= (cript_or_decript_signal == ENC) ? S1 : S9;
        end
        S1:  begin st <= st ^ ky;    state <= S2;  end
        S2:  state <= S3;
        S3:  begin st <= sub(st);    state <= S4;  end
        S4:  begin st <= shift(st);  state <= S5;  end
        S5: begin
          cnt <= cnt + 3'd1;
          if (mode == ENC) state <= S6;
          else             state <= (cnt + 3'd1 < 3'd4) ? S16 : S17;
        end
        S6: begin
          if (cnt < 3'd4) st <= mix(st);
          state <= S7;
        end
        S7:  begin ky <= sub(ky);    state <= S8;  end
        S8:  begin st <= st ^ ky;    state <= (cnt < 3'd4) ? S2 : S19; end
        S9:  begin st <= st ^ ky;    state <= S11; end
        S10: state <= S11;
        S11: begin st <= shift(st);  state <= S12; end
        S12: begin st <= isub(st);   state <= S14; end
        S14: begin ky <= isub(ky);   state <= S15; end
        S15: begin st <= st ^ ky;    state <= S5;  end
        S16: begin st <= mix(st);    state <= S10; end
        S17: state <= S18;
        S18: state <= S20;
        S19: state <= S20;
        S20: begin data_outbus <= st; state <= S21;  end
        S21: begin key_outbus  <= ky; state <= IDLE; end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crypto_block.sv
// Directed bench for crypto_block: known-answer vectors, round trips, latency, strobes, reset.
module tb_crypto_block;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] key_in = '0, data_in = '0;
  logic [1:0]  mode_in = '0;
  logic        bgn = 1'b0;
  logic        c00, c01, c02, c03, c04, c05, c06, c07, c08, c09, c010;
  logic        c011, c012, c013, c014, c015, c016, c017, c018, c019, c020, c021;
  logic [2:0]  counter;
  logic [15:0] key_out, data_out;
  logic [21:0] cv;
  logic [15:0] ct, kt, pt, k0;
  int          checks = 0, failures = 0, c20_seen = 0, c20_base;

  crypto_block dut (
    .clk(clk), .rst(rst), .key_inbus(key_in), .data_inbus(data_in),
    .cript_or_decript_signal(mode_in), .bgn(bgn),
    .c00(c00), .c01(c01), .c02(c02), .c03(c03), .c04(c04), .c05(c05), .c06(c06),
    .c07(c07), .c08(c08), .c09(c09), .c010(c010), .c011(c011), .c012(c012),
    .c013(c013), .c014(c014), .c015(c015), .c016(c016), .c017(c017), .c018(c018),
    .c019(c019), .c020(c020), .c021(c021),
    .counter(counter), .key_outbus(key_out), .data_outbus(data_out)
  );

  always #5 clk = ~clk;

  assign cv = {c021, c020, c019, c018, c017, c016, c015, c014, c013, c012, c011,
               c010, c09, c08, c07, c06, c05, c04, c03, c02, c01, c00};

  always @(negedge clk) if (c020) c20_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Returns 1 time unit after the edge that samples bgn.
  task automatic start(input logic [1:0] m, input logic [15:0] k, input logic [15:0] d);
    @(negedge clk);
    mode_in = m; key_in = k; data_in = d; bgn = 1'b1;
    @(posedge clk);
    #1 bgn = 1'b0;
  endtask

  task automatic run(input logic [1:0] m, input logic [15:0] k, input logic [15:0] d,
                     output logic [15:0] dout, output logic [15:0] kout);
    int lat;
    lat = (m == 2'b01) ? 32 : 31;
    start(m, k, d);
    edges(1);
    key_in = 16'($urandom); data_in = 16'($urandom); mode_in = 2'b11;
    edges(lat - 1);
    dout = data_out;
    edges(1);
    kout = key_out;
  endtask

  initial begin
    #1 rst = 1'b1;
    #20;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_key", 32'(key_out), 32'h0);
    check("rst_counter", 32'(counter), 32'h0);
    check("rst_strobes", 32'(cv), 32'h0);
    @(negedge clk) rst = 1'b0;

    // Encrypt known answer with latency and strobe trace
    c20_base = c20_seen;
    start(2'b01, 16'h0000, 16'h0000);
    edges(1);
    check("c00_first", 32'(c00), 32'h1);
    check("c01_not_yet", 32'(c01), 32'h0);
    edges(1);
    check("c01_next", 32'(c01), 32'h1);
    edges(5);
    check("counter_r1", 32'(counter), 32'h1);
    edges(7);
    check("counter_r2", 32'(counter), 32'h2);
    edges(14);
    check("counter_r4", 32'(counter), 32'h4);
    edges(3);
    check("enc_data_edge31", 32'(data_out), 32'h0000);
    edges(1);
    check("enc_data_edge32", 32'(data_out), 32'hA8A9);
    check("enc_key_edge32", 32'(key_out), 32'h0000);
    edges(1);
    check("enc_key_edge33", 32'(key_out), 32'h7676);
    edges(2);
    check("c020_once", 32'(c20_seen - c20_base), 32'h1);

    // Decrypt known answer with latency
    start(2'b10, 16'h7676, 16'hA8A9);
    edges(30);
    check("dec_data_edge30", 32'(data_out), 32'hA8A9);
    edges(1);
    check("dec_data_edge31", 32'(data_out), 32'h0000);
    check("dec_key_edge31", 32'(key_out), 32'h7676);
    edges(1);
    check("dec_key_edge32", 32'(key_out), 32'h0000);

    // Round trips; encrypt key results follow from four S-box passes on each key byte
    run(2'b01, 16'h1325, 16'h59B3, ct, kt);
    check("rt1_enc_key", 32'(kt), 32'h475E);
    run(2'b10, kt, ct, pt, k0);
    check("rt1_data", 32'(pt), 32'h59B3);
    check("rt1_key", 32'(k0), 32'h1325);
    run(2'b01, 16'hA058, 16'h36CB, ct, kt);
    check("rt2_enc_key", 32'(kt), 32'h41F5);
    run(2'b10, kt, ct, pt, k0);
    check("rt2_data", 32'(pt), 32'h36CB);
    check("rt2_key", 32'(k0), 32'hA058);

    // No-op modes must not start
    @(negedge clk);
    mode_in = 2'b00; bgn = 1'b1; key_in = 16'h1111; data_in = 16'h2222;
    edges(5);
    check("nop00_strobes", 32'(cv), 32'h0);
    check("nop00_data", 32'(data_out), 32'h36CB);
    check("nop00_key", 32'(key_out), 32'hA058);
    mode_in = 2'b11;
    edges(3);
    check("nop11_strobes", 32'(cv), 32'h0);
    bgn = 1'b0;

    // Reset during round 2 of an encrypt
    start(2'b01, 16'h1325, 16'h59B3);
    edges(14);
    check("mid_counter_r2", 32'(counter), 32'h2);
    rst = 1'b1;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_key", 32'(key_out), 32'h0);
    check("mid_rst_counter", 32'(counter), 32'h0);
    check("mid_rst_strobes", 32'(cv), 32'h0);
    @(negedge clk) rst = 1'b0;
    edges(4);
    check("post_rst_idle", 32'(cv), 32'h0);
    run(2'b01, 16'h0000, 16'h0000, ct, kt);
    check("restart_data", 32'(ct), 32'hA8A9);
    check("restart_key", 32'(kt), 32'h7676);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
